// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN streaming stages.
// relu is written at MAX_W so that any sample width up to MAX_W can call it.
package cnn_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned MAX_W    = 64;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // The sign bit decides, so the most negative value also clamps to zero.
    function automatic logic signed [MAX_W-1:0] relu(input logic signed [MAX_W-1:0] x);
        return x[MAX_W-1] ? '0 : x;
    endfunction

endpackage

// File: rtl/pool_fifo.sv
// Synchronous FIFO with a registered head that holds its last value once drained.
module pool_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head_data
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            head_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
            // Head loads the pushed word only when it becomes the sole entry.
            if (do_push && (empty || (do_pop && count == CW'(1)))) begin
                head_data <= push_data;
            end else if (do_pop && count > CW'(1)) begin
                head_data <= mem[ptr_inc(rd_ptr)];
            end
        end
    end

endmodule

// File: rtl/relu_maxpool_stream.sv
// ReLU followed by non-overlapping max-pooling over fixed-length frames,
// buffered by a small output FIFO.
module relu_maxpool_stream
    import cnn_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LENY  = 24,
    parameter int unsigned POOL  = 2,
    parameter int unsigned DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] s_data_in_y,
    input  logic                    s_valid_y,
    output logic                    s_ready_y,
    output logic signed [WIDTH-1:0] m_data_out_z,
    output logic                    m_valid_z,
    input  logic                    m_ready_z
);

    localparam int unsigned OUTLEN  = (LENY + POOL - 1) / POOL;
    localparam bit          PARTIAL = (OUTLEN * POOL) != LENY;
    localparam int unsigned EW      = (LENY > 1) ? $clog2(LENY) : 1;
    localparam int unsigned WW      = (POOL > 1) ? $clog2(POOL) : 1;
    localparam int unsigned CW      = $clog2(DEPTH+1);

    logic [EW-1:0]           elem_cnt;
    logic [WW-1:0]           win_cnt;
    logic signed [WIDTH-1:0] max_reg;
    logic signed [WIDTH-1:0] relu_x;
    logic signed [WIDTH-1:0] cand;
    logic                    accept;
    logic                    last_in_win;
    logic                    last_in_frame;
    logic                    close_win;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_count;
    logic [WIDTH-1:0]        fifo_head;

    assign accept        = s_valid_y & s_ready_y;
    assign last_in_win   = (win_cnt == WW'(POOL-1));
    assign last_in_frame = (elem_cnt == EW'(LENY-1));
    // Without a partial tail the frame end always coincides with a window end.
    assign close_win     = last_in_win | (PARTIAL & last_in_frame);

    always_comb begin
        relu_x = WIDTH'(relu({{(MAX_W-WIDTH){s_data_in_y[WIDTH-1]}}, s_data_in_y}));
        cand   = relu_x;
        if (win_cnt != '0 && max_reg > relu_x) begin
            cand = max_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            elem_cnt <= '0;
            win_cnt  <= '0;
            max_reg  <= '0;
        end else if (accept) begin
            max_reg  <= cand;
            elem_cnt <= last_in_frame ? '0 : elem_cnt + 1'b1;
            win_cnt  <= close_win ? '0 : win_cnt + 1'b1;
        end
    end

    pool_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept & close_win),
        .push_data (cand),
        .pop       (m_valid_z & m_ready_z),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head_data (fifo_head)
    );

    assign s_ready_y    = ~fifo_full;
    assign m_valid_z    = ~fifo_empty;
    assign m_data_out_z = fifo_head;

    count_in_range: assert property (@(posedge clk) disable iff (reset)
        fifo_count <= CW'(DEPTH));

endmodule

// File: tb/tb_relu_maxpool_stream.sv
// Directed bench: default instance plus a POOL=5 instance sharing clock and reset.
module tb_relu_maxpool_stream;

    logic clk = 1'b0;
    logic reset;

    logic signed [15:0] s_data, s_data5;
    logic               s_valid, s_valid5;
    logic               s_ready, s_ready5;
    logic signed [15:0] m_data, m_data5;
    logic               m_valid, m_valid5;
    logic               m_ready, m_ready5;

    int n_cmp = 0;
    int n_err = 0;
    int q[$];
    int q5[$];
    int exp_q[$];

    always #5 clk = ~clk;

    relu_maxpool_stream dut (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_y  (s_data),
        .s_valid_y    (s_valid),
        .s_ready_y    (s_ready),
        .m_data_out_z (m_data),
        .m_valid_z    (m_valid),
        .m_ready_z    (m_ready)
    );

    relu_maxpool_stream #(
        .POOL (5)
    ) dut5 (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_y  (s_data5),
        .s_valid_y    (s_valid5),
        .s_ready_y    (s_ready5),
        .m_data_out_z (m_data5),
        .m_valid_z    (m_valid5),
        .m_ready_z    (m_ready5)
    );

    // Record every completed output handshake.
    always @(negedge clk) begin
        if (!reset && m_valid && m_ready) q.push_back(int'(m_data));
        if (!reset && m_valid5 && m_ready5) q5.push_back(int'(m_data5));
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cmp_stream(input string tag, input int got[$], input int exp[$]);
        check_eq({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) check_eq($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
        end
    endtask

    task automatic send(input int x);
        bit ok = 1'b0;
        int guard = 0;
        s_valid = 1'b1;
        s_data  = 16'(x);
        while (!ok && guard < 100) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!ok) check_eq("accept_timeout", int'(ok), 1);
    endtask

    task automatic send5(input int x);
        bit ok = 1'b0;
        int guard = 0;
        s_valid5 = 1'b1;
        s_data5  = 16'(x);
        while (!ok && guard < 100) begin
            @(negedge clk);
            ok = s_ready5;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!ok) check_eq("accept5_timeout", int'(ok), 1);
    endtask

    task automatic idle(input int n);
        s_valid  = 1'b0;
        s_valid5 = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        s_valid  = 1'b0;
        s_valid5 = 1'b0;
        reset    = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        q5.delete();
    endtask

    task automatic build_evens();
        exp_q.delete();
        for (int i = 2; i <= 24; i += 2) exp_q.push_back(i);
    endtask

    initial begin
        reset    = 1'b1;
        s_data   = '0;
        s_data5  = '0;
        s_valid  = 1'b0;
        s_valid5 = 1'b0;
        m_ready  = 1'b1;
        m_ready5 = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        do_reset(2);
        check_eq("rst_m_valid", int'(m_valid), 0);
        check_eq("rst_m_data", int'(m_data), 0);
        check_eq("rst_s_ready", int'(s_ready), 1);
        check_eq("rst_m_valid5", int'(m_valid5), 0);
        check_eq("rst_s_ready5", int'(s_ready5), 1);

        // Ramp with free-flowing output: head shows the even sample right after its accept
        for (int i = 1; i <= 24; i++) begin
            send(i);
            check_eq($sformatf("ramp_s_ready_%0d", i), int'(s_ready), 1);
            if (i % 2 == 0) begin
                check_eq($sformatf("ramp_valid_%0d", i), int'(m_valid), 1);
                check_eq($sformatf("ramp_head_%0d", i), int'(m_data), i);
            end
        end
        idle(4);
        build_evens();
        cmp_stream("ramp", q, exp_q);

        // Sign handling and extremes
        do_reset(1);
        send(-5); send(-3); send(-7); send(300);
        send(32767); send(-32768); send(-32768); send(-32768);
        idle(4);
        exp_q = '{0, 300, 32767, 0};
        cmp_stream("sign", q, exp_q);

        // Back-pressure: FIFO fills after four accepts, fifth stalls
        do_reset(1);
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(i);
        check_eq("bp_s_ready_full", int'(s_ready), 0);
        check_eq("bp_head", int'(m_data), 2);
        s_valid = 1'b1;
        s_data  = 16'sd5;
        repeat (3) @(posedge clk);
        #1;
        check_eq("bp_head_hold", int'(m_data), 2);
        check_eq("bp_valid_hold", int'(m_valid), 1);
        check_eq("bp_none_popped", q.size(), 0);
        m_ready = 1'b1;
        for (int i = 5; i <= 24; i++) send(i);
        idle(6);
        build_evens();
        cmp_stream("bp", q, exp_q);

        // POOL=5: partial tail window, then an all-negative frame
        do_reset(1);
        for (int i = 1; i <= 24; i++) send5(i);
        for (int i = 0; i < 24; i++) send5(-1);
        idle(4);
        exp_q = '{5, 10, 15, 20, 24, 0, 0, 0, 0, 0};
        cmp_stream("pool5", q5, exp_q);

        // Reset mid-frame with a sample queued and a partial window pending
        do_reset(1);
        for (int i = 1; i <= 5; i++) send(i);
        m_ready = 1'b0;
        send(6);
        send(7);
        idle(1);
        exp_q = '{2, 4};
        cmp_stream("pre_rst", q, exp_q);
        check_eq("pre_rst_head", int'(m_data), 6);
        do_reset(1);
        check_eq("mid_rst_m_valid", int'(m_valid), 0);
        check_eq("mid_rst_m_data", int'(m_data), 0);
        check_eq("mid_rst_s_ready", int'(s_ready), 1);
        m_ready = 1'b1;
        for (int i = 1; i <= 24; i++) send(i);
        idle(6);
        build_evens();
        cmp_stream("post_rst", q, exp_q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
